ext_inm_pipe: RTL and testbench
===============================

Name: ext_inm_pipe

Overview:
- Parametrised, registered immediate/displacement extender with valid/ready handshakes on both sides.
- Generalises the fixed 13→32 sign extender: any input/output width, sign or zero extension, optional left shift for word-aligned branch/call displacements (disp22/disp30).
- Sits between decode field extraction and the PC/ALU operand muxes.
- A 2-entry output buffer absorbs back-pressure without dropping an accepted value.

Parameters:
- IN_W, 13, width of the raw immediate field.
- OUT_W, 32, width of the extended result.
- LSH, 2, shift amount applied when shift mode is selected. Elaboration constraint: OUT_W ≥ IN_W + LSH, otherwise `$error`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Entrada  input  IN_W  raw immediate field.
- Modo  input  2  bit0: 0 = sign extend, 1 = zero extend; bit1: 1 = shift left by LSH after extension.
- in_valid  input  1  Entrada/Modo valid this cycle.
- in_ready  output  1  block can accept a value this cycle.
- flush  input  1  synchronous discard of all buffered entries (branch redirect).
- Salida  output  OUT_W  extended result at buffer head.
- out_valid  output  1  Salida valid.
- out_ready  input  1  consumer takes Salida this cycle.
- cuenta  output  2  current buffer occupancy (0..2).

Behaviour:
- Extension is combinational at the input and stored into the buffer on acceptance.
  - Sign mode: bits [OUT_W-1:IN_W] = Entrada[IN_W-1].
  - Zero mode: those bits = 0.
  - Shift mode: the extended value is shifted left by LSH, zeros fill the low bits, and bits shifted past OUT_W are discarded. Because the extension to OUT_W happens before the shift, sign is preserved when OUT_W ≥ IN_W+LSH.
- Modo is sampled with Entrada at the accept edge. A Modo change after acceptance does not affect stored entries.
- Push happens when in_valid && in_ready. Pop happens when out_valid && out_ready.
- Buffer is a 2-entry circular queue: wr_ptr, rd_ptr (1 bit each), count (0..2).
  - in_ready = (count < 2), registered-state-derived only. There is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
  - Salida = mem[rd_ptr]. When count == 0, Salida holds its last value and is don't-care.
- Latency: a value accepted at edge N appears with out_valid = 1 in the cycle after edge N. There is no same-cycle bypass.
- Throughput: 1 value/cycle sustained while out_ready = 1.
- Simultaneous push and pop with count = 1: count stays 1, both pointers advance, and the new entry becomes the head after the pop.
- count = 2: in_ready = 0, so in_valid is ignored. A pop that cycle frees one slot and in_ready rises the next cycle.
- count = 0 with pop attempted: impossible, because out_valid = 0.
- Pointer wrap: 1-bit pointers toggle naturally (1→0).
- flush = 1 has priority over push and pop. On the next edge count = 0 and wr_ptr = rd_ptr = 0. A value presented with in_valid that same cycle is dropped, even if in_ready = 1.
- Reset (asynchronous, any time including mid-transfer): count = 0, pointers = 0, out_valid = 0, in_ready = 1 while reset is deasserted afterwards, cuenta = 0, Salida = 0 (mem cleared).
  - While reset = 1, in_ready is forced to 0.
  - Release is synchronised by the system. The block needs no extra cycle after release.

Test Plan:
- Sign/zero with IN_W=13, OUT_W=32, LSH=2, out_ready=1:
  - Entrada=13'h1FFF, Modo=00 → Salida=32'hFFFFFFFF one cycle later.
  - Modo=01 → Salida=32'h00001FFF.
  - Entrada=13'h0ABC, Modo=00 → Salida=32'h00000ABC.
- Shift modes:
  - Entrada=13'h1000, Modo=10 → Salida=32'hFFFFC000.
  - Entrada=13'h0FFF, Modo=10 → Salida=32'h00003FFC.
  - Entrada=13'h1000, Modo=11 → Salida=32'h00004000.
- Back-pressure: out_ready=0, push 13'h0001, 13'h0002, 13'h0003 on consecutive cycles (Modo=00).
  - Expect cuenta = 1, then 2; in_ready = 0 at the third cycle; third value not accepted.
  - Then set out_ready=1: outputs 1, 2 in order; in_ready returns to 1 after the first pop.
- Streaming with simultaneous push/pop at count=1: 8 back-to-back values 0..7 with out_ready=1.
  - Expect outputs 0..7 in order, one per cycle, cuenta steady at 1, no bubbles.
- Flush: fill to count=2, then assert flush together with in_valid (Entrada=13'h0055).
  - Next cycle: cuenta=0, out_valid=0, 13'h0055 never emitted.
- Reset mid-operation: count=2, assert reset between clock edges.
  - out_valid drops immediately (asynchronous), Salida=0, in_ready=0 during reset, 1 after release.
  - Next push of 13'h0007 emerges as 32'h00000007 with no stale data.

Source files
------------

// File: rtl/ext_inm_pipe.sv
// Registered immediate/displacement extender (sign/zero extend, optional left shift)
// with valid/ready handshakes and a 2-entry output queue that absorbs back-pressure.
module ext_inm_pipe #(
    parameter int unsigned IN_W  = 13,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned LSH   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  Entrada,
    input  logic [1:0]       Modo,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] Salida,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       cuenta
);

    if (OUT_W < IN_W + LSH) begin : g_width_chk
        $error("ext_inm_pipe: OUT_W must be >= IN_W + LSH");
    end

    logic [OUT_W-1:0] ext_val;
    logic [OUT_W-1:0] res_val;
    logic             fill_bit;

    // Extend to full width before shifting so the sign survives the shift.
    always_comb begin
        fill_bit = Modo[0] ? 1'b0 : Entrada[IN_W-1];
        ext_val  = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            ext_val[i] = (i < int'(IN_W)) ? Entrada[i] : fill_bit;
        end
        res_val = Modo[1] ? (ext_val << LSH) : ext_val;
    end

    logic [OUT_W-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign in_ready  = (count_q < 2'd2) && !reset;
    assign out_valid = (count_q != 2'd0);
    assign Salida    = mem_q[rd_ptr_q];
    assign cuenta    = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= res_val;
            end
        end
    end

endmodule

// File: tb/tb_ext_inm_pipe.sv
// Bench for ext_inm_pipe: directed cases plus random traffic checked against a
// queue-based reference model using plain arithmetic for the extension.
module tb_ext_inm_pipe;

    localparam int IN_W  = 13;
    localparam int OUT_W = 32;
    localparam int LSH   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  Entrada;
    logic [1:0]       Modo;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [OUT_W-1:0] Salida;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       cuenta;

    int total = 0;
    int bad   = 0;
    logic [31:0] q[$];

    ext_inm_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LSH(LSH)) dut (
        .clk      (clk),
        .reset    (reset),
        .Entrada  (Entrada),
        .Modo     (Modo),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .Salida   (Salida),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cuenta   (cuenta)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_ext(input logic [IN_W-1:0] e, input logic [1:0] m);
        longint v;
        v = longint'(e);
        if (!m[0] && v >= (longint'(1) << (IN_W - 1))) v = v - (longint'(1) << IN_W);
        if (m[1]) v = v * (longint'(1) << LSH);
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, then advance one edge and update the model.
    task automatic tick();
        logic do_pop, do_push;
        logic [31:0] nv;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("cuenta", {30'd0, cuenta}, q.size());
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() != 0) chk("salida_head", Salida, q[0]);
        do_pop  = !flush && out_ready && q.size() != 0;
        do_push = !flush && in_valid && q.size() < 2;
        nv = model_ext(Entrada, Modo);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(nv);
        end
    endtask

    task automatic push_one(input logic [IN_W-1:0] e, input logic [1:0] m,
                            input logic [31:0] exp, input string tag);
        Entrada  = e;
        Modo     = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        Modo     = ~m;
        chk(tag, Salida, exp);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        Entrada   = '0;
        Modo      = 2'b00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_cuenta", {30'd0, cuenta}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_salida", Salida, 32'd0);
        chk("rst_in_ready_rel", {31'd0, in_ready}, 32'd1);

        // Sign/zero extension and shift modes.
        push_one(13'h1FFF, 2'b00, 32'hFFFFFFFF, "sext_neg");
        push_one(13'h1FFF, 2'b01, 32'h00001FFF, "zext");
        push_one(13'h0ABC, 2'b00, 32'h00000ABC, "sext_pos");
        push_one(13'h1000, 2'b10, 32'hFFFFC000, "shift_sext_neg");
        push_one(13'h0FFF, 2'b10, 32'h00003FFC, "shift_sext_pos");
        push_one(13'h1000, 2'b11, 32'h00004000, "shift_zext");

        // Back-pressure: third value must be refused.
        out_ready = 1'b0;
        Modo      = 2'b00;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            Entrada = IN_W'(i);
            tick();
            chk("bp_cuenta", {30'd0, cuenta}, (i == 1) ? 32'd1 : 32'd2);
        end
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_head1", Salida, 32'd1);
        tick();
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        chk("bp_head2", Salida, 32'd2);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming: push and pop together at count 1.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Entrada = IN_W'(i);
            tick();
            chk("stream_cuenta", {30'd0, cuenta}, 32'd1);
            chk("stream_data", Salida, i);
        end
        in_valid = 1'b0;
        tick();
        tick();

        // Flush with a simultaneous push.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Entrada   = 13'h0011;
        tick();
        Entrada   = 13'h0022;
        tick();
        flush     = 1'b1;
        Entrada   = 13'h0055;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("flush_cuenta", {30'd0, cuenta}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        tick();

        // Asynchronous reset while full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Entrada   = 13'h0123;
        tick();
        tick();
        in_valid = 1'b0;
        chk("pre_rst_cuenta", {30'd0, cuenta}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_salida", Salida, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_in_ready_rel", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        push_one(13'h0007, 2'b00, 32'h00000007, "post_rst");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            Entrada   = IN_W'($urandom);
            Modo      = 2'($urandom);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
